pattern_cmd_responder: RTL and testbench
========================================

PATTERN_CMD_RESPONDER -- requirements
Module: pattern_cmd_responder

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, system clock frequency in Hz (documentation and timeout derivation only).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1250000, inter-byte idle limit in clocks (50 ms at 25 MHz).
REQ-003 SHALL have port clk  input  1  system clock; sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  byte from UART receiver, valid only while rx_valid is high.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe per received byte.
REQ-007 SHALL have port tx_data  output  8  byte to UART transmitter, held stable while tx_start is high.
REQ-008 SHALL have port tx_start  output  1  one-cycle request to transmit tx_data.
REQ-009 SHALL have port tx_busy  input  1  transmitter busy; goes high the cycle after an accepted tx_start.
REQ-010 SHALL have port mem_addr  output  8  pattern memory address.
REQ-011 SHALL have port mem_wdata  output  72  pattern word to write.
REQ-012 SHALL have port mem_we  output  1  one-cycle write strobe.
REQ-013 SHALL have port mem_rdata  input  72  pattern word read at mem_addr, valid one cycle after mem_addr changes.
REQ-014 SHALL have port frame_error  output  1  one-cycle pulse on timeout abort or byte dropped while responding.

Function
REQ-015 SHALL implement states IDLE, GET_ADDR, GET_DATA, COMMIT, READ_WAIT, SEND.
REQ-016 IDLE: rx "w" (8'h77) -> GET_ADDR, mode write; rx "r" (8'h72) -> GET_ADDR, mode read; any other byte -> SEND with single reply "?" (8'h3F).
REQ-017 GET_ADDR: next rx byte latched into mem_addr; write mode -> GET_DATA with byte count 0; read mode -> READ_WAIT.
REQ-018 GET_DATA: each rx byte shifts into a 72-bit register from the LSB end (first byte ends as bits 71:64, big-endian); after the 9th byte -> COMMIT.
REQ-019 COMMIT: mem_we high for exactly one cycle, the cycle after the 9th byte's rx_valid, with mem_addr and mem_wdata stable; then SEND with single reply "o" (8'h6F).
REQ-020 READ_WAIT: one cycle; mem_rdata captured into the shift register at its end; then SEND with 9 reply bytes, bits 71:64 first.
REQ-021 SEND: pulse tx_start only when tx_busy is low; ignore tx_busy in the cycle after a pulse; after the last reply byte's pulse and tx_busy low again -> IDLE.
REQ-022 tx_start SHALL never be high in two consecutive cycles; tx_data SHALL change only in cycles with tx_start low.
REQ-023 Bytes arriving in COMMIT, READ_WAIT or SEND SHALL be discarded and pulse frame_error; state unaffected.
REQ-024 In GET_ADDR or GET_DATA, a 32-bit idle counter counts clocks since the last rx_valid; reaching TIMEOUT_CYCLES -> IDLE, frame_error pulse, no mem_we; counter clears on every rx_valid.
REQ-025 Inter-byte gaps below TIMEOUT_CYCLES (including 1 ms) SHALL be accepted without error.
REQ-026 mem_we SHALL never assert outside COMMIT; at most one mem_we per complete "w" frame.

Reset
REQ-027 On rst high at a clock edge: state IDLE; tx_start, mem_we, frame_error 0; tx_data, mem_addr 8'h00; mem_wdata 72'h0; counters 0.
REQ-028 Reset mid-frame or mid-reply SHALL abandon it: no mem_we, no further tx_start.
REQ-029 Reset held across multiple cycles SHALL keep all outputs at reset values.

Structure
REQ-030 Command/reply byte constants ("w", "r", "o", "?"), the 9-byte frame length and the state enumeration SHALL live in a shared package used by the top-level lights block and benches.
REQ-031 Single module, no sub-modules; the UART receiver/transmitter and pattern memory stay external.

Verification
REQ-032 rx "w",AA,00,01,02,03,04,05,06,07,08 with random gaps up to 1 ms -> one mem_we, mem_addr 8'hAA, mem_wdata 72'h000102030405060708, then one tx byte "o".
REQ-033 After REQ-032, rx "r",AA with mem model -> tx bytes 00,01,...,08 in order, each tx_start only while tx_busy low.
REQ-034 rx "w",AA,00,01 then idle TIMEOUT_CYCLES+10 clocks -> frame_error pulse, no mem_we, no tx; following full frame to addr 8'h10 writes correctly and returns "o".
REQ-035 rx "x" (8'h78) -> single tx "?", no mem_we; rx byte injected during reply -> frame_error pulse, reply unaffected.
REQ-036 rst asserted after the 5th data byte of a "w" frame -> no mem_we, no tx; subsequent full frame succeeds with "o".

Source files
------------

// File: rtl/pattern_cmd_responder_pkg.sv
// pattern_cmd_responder_pkg: command/reply bytes, write frame length and FSM states
package pattern_cmd_responder_pkg;
   localparam logic [7:0] CMD_WRITE   = 8'h77;
   localparam logic [7:0] CMD_READ    = 8'h72;
   localparam logic [7:0] RSP_OK      = 8'h6F;
   localparam logic [7:0] RSP_ERR     = 8'h3F;
   localparam int         FRAME_BYTES = 9;
   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, COMMIT, READ_WAIT, SEND} state_t;
endpackage

// File: rtl/pattern_cmd_responder.sv
// pattern_cmd_responder: UART byte protocol that writes/reads 72-bit words of an external pattern memory
module pattern_cmd_responder
   import pattern_cmd_responder_pkg::*;
#(
   parameter int CLK_HZ         = 25000000,
   parameter int TIMEOUT_CYCLES = CLK_HZ / 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic [7:0]  mem_addr,
   output logic [71:0] mem_wdata,
   output logic        mem_we,
   input  logic [71:0] mem_rdata,
   output logic        frame_error
);
   state_t      r_state;
   logic        r_wr_mode;
   logic        r_hold;
   logic [3:0]  r_cnt;
   logic [3:0]  r_left;
   logic [31:0] r_idle;
   logic [71:0] r_shift;
   logic [7:0]  r_tx_data;
   logic        r_tx_start;
   logic [7:0]  r_mem_addr;
   logic        r_mem_we;
   logic        r_frame_error;
   logic        w_rx_state;
   logic        w_busy_state;
   logic        w_timeout;
   assign w_rx_state   = r_state == GET_ADDR || r_state == GET_DATA;
   assign w_busy_state = r_state == COMMIT || r_state == READ_WAIT || r_state == SEND;
   assign w_timeout    = w_rx_state && !rx_valid && r_idle == 32'(TIMEOUT_CYCLES - 1);
   assign tx_data      = r_tx_data;
   assign tx_start     = r_tx_start;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_shift;
   assign mem_we       = r_mem_we;
   assign frame_error  = r_frame_error;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_wr_mode     <= 1'b0;
         r_hold        <= 1'b0;
         r_cnt         <= '0;
         r_left        <= '0;
         r_idle        <= '0;
         r_shift       <= '0;
         r_tx_data     <= '0;
         r_tx_start    <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_we      <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_mem_we      <= 1'b0;
         r_frame_error <= w_timeout || (rx_valid && w_busy_state);
         r_idle        <= (rx_valid || !w_rx_state) ? '0 : r_idle + 32'd1;
         if (w_timeout) r_state <= IDLE;
         else case (r_state)
            IDLE: if (rx_valid) begin
               r_wr_mode <= rx_data == CMD_WRITE;
               if (rx_data == CMD_WRITE || rx_data == CMD_READ) r_state <= GET_ADDR;
               else begin
                  r_shift <= {RSP_ERR, 64'h0};
                  r_left  <= 4'd1;
                  r_state <= SEND;
               end
            end
            GET_ADDR: if (rx_valid) begin
               r_mem_addr <= rx_data;
               r_cnt      <= '0;
               r_state    <= r_wr_mode ? GET_DATA : READ_WAIT;
            end
            GET_DATA: if (rx_valid) begin
               r_shift <= {r_shift[63:0], rx_data};
               r_cnt   <= r_cnt + 4'd1;
               if (r_cnt == 4'(FRAME_BYTES - 1)) begin
                  r_mem_we <= 1'b1;
                  r_state  <= COMMIT;
               end
            end
            COMMIT: begin
               r_shift <= {RSP_OK, 64'h0};
               r_left  <= 4'd1;
               r_state <= SEND;
            end
            READ_WAIT: begin
               r_shift <= mem_rdata;
               r_left  <= 4'(FRAME_BYTES);
               r_state <= SEND;
            end
            SEND: begin
               // busy only rises the cycle after a pulse, so skip that cycle before trusting it
               if (r_tx_start) begin
                  r_tx_start <= 1'b0;
                  r_hold     <= 1'b1;
               end else if (r_hold) r_hold <= 1'b0;
               else if (!tx_busy) begin
                  if (r_left == '0) r_state <= IDLE;
                  else begin
                     r_tx_start <= 1'b1;
                     r_tx_data  <= r_shift[71:64];
                     r_shift    <= {r_shift[63:0], 8'h00};
                     r_left     <= r_left - 4'd1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pattern_cmd_responder.sv
// tb_pattern_cmd_responder: scoreboarded bench with a transmitter busy model and a pattern memory model
module tb_pattern_cmd_responder;
   import pattern_cmd_responder_pkg::*;
   localparam int CLK_HZ = 100000;
   localparam int TMO    = 500;
   localparam int MS     = CLK_HZ / 1000;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic [7:0]  mem_addr;
   logic [71:0] mem_wdata;
   logic        mem_we;
   logic [71:0] mem_rdata;
   logic        frame_error;
   logic [71:0] mem [256];
   logic [71:0] model [256];
   logic [7:0]  exp_tx [$];
   logic [7:0]  exp_wa [$];
   logic [71:0] exp_wd [$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_rx = 0;
   int          fe_cnt = 0;
   int          fe0 = 0;
   int          busy_cnt = 0;
   logic        prev_start = 1'b0;
   always #5 clk = ~clk;
   pattern_cmd_responder #(.CLK_HZ(CLK_HZ), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .frame_error(frame_error)
   );
   assign mem_rdata = mem[mem_addr];
   assign tx_busy   = busy_cnt != 0;
   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rx_valid) last_rx <= cyc;
      if (tx_start) busy_cnt <= $urandom_range(3, 12);
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end
   always @(negedge clk) begin
      if (rst) prev_start = 1'b0;
      else begin
         if (frame_error) fe_cnt++;
         if (tx_start) begin
            chk("tx_while_busy", tx_busy, 0);
            chk("tx_back_to_back", prev_start, 0);
            if (exp_tx.size() == 0) chk("tx_unexpected", exp_tx.size(), 1);
            else chk("tx_byte", tx_data, exp_tx.pop_front());
         end
         if (mem_we) begin
            chk("we_latency", cyc - last_rx, 1);
            if (exp_wa.size() == 0) chk("we_unexpected", exp_wa.size(), 1);
            else begin
               chk("we_addr", mem_addr, exp_wa.pop_front());
               chk("we_data", mem_wdata, exp_wd.pop_front());
            end
         end
         prev_start = tx_start;
      end
   end
   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask
   task automatic write_frame(input logic [7:0] a, input logic [71:0] d, input int max_gap);
      logic [71:0] s;
      s = d;
      model[a] = d;
      exp_wa.push_back(a);
      exp_wd.push_back(d);
      exp_tx.push_back(RSP_OK);
      send_byte(CMD_WRITE, $urandom_range(1, max_gap));
      send_byte(a, $urandom_range(1, max_gap));
      for (int i = 0; i < FRAME_BYTES; i++) begin
         send_byte(s[71:64], $urandom_range(1, max_gap));
         s = s << 8;
      end
   endtask
   task automatic read_frame(input logic [7:0] a);
      logic [71:0] s;
      s = model[a];
      for (int i = 0; i < FRAME_BYTES; i++) begin
         exp_tx.push_back(s[71:64]);
         s = s << 8;
      end
      send_byte(CMD_READ, 2);
      send_byte(a, 0);
   endtask
   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_tx.size() != 0 || exp_wa.size() != 0) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      chk("drain", exp_tx.size() + exp_wa.size(), 0);
      repeat (20) @(posedge clk);
   endtask
   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tx_start"}, tx_start, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_frame_error"}, frame_error, 0);
      chk({tag, "_tx_data"}, tx_data, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
   endtask
   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]   = '0;
         model[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      write_frame(8'hAA, 72'h000102030405060708, MS);
      wait_done();
      read_frame(8'hAA);
      wait_done();
      fe0 = fe_cnt;
      send_byte(CMD_WRITE, 1);
      send_byte(8'hAA, 1);
      send_byte(8'h00, 1);
      send_byte(8'h01, 1);
      repeat (TMO + 10) @(posedge clk);
      chk("timeout_fe", fe_cnt - fe0, 1);
      write_frame(8'h10, {$urandom(), $urandom(), 8'($urandom())}, 5);
      wait_done();
      read_frame(8'h10);
      wait_done();
      fe0 = fe_cnt;
      exp_tx.push_back(RSP_ERR);
      send_byte(8'h78, 1);
      wait_done();
      chk("unknown_fe", fe_cnt - fe0, 0);
      read_frame(8'h10);
      repeat (15) @(posedge clk);
      send_byte(8'h55, 1);
      wait_done();
      chk("inject_fe", fe_cnt - fe0, 1);
      send_byte(CMD_WRITE, 1);
      send_byte(8'h20, 1);
      for (int i = 0; i < 5; i++) send_byte(8'(8'hD0 + i), 1);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("held_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (30) @(posedge clk);
      write_frame(8'h20, 72'hFEDCBA987654321001, 3);
      wait_done();
      read_frame(8'h20);
      wait_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
